// File: rtl/scope_trace_capture.sv
// ---------------------------------------------------------------------------
// scope_trace_capture
//
// Acquisition front end for the scope display. ADC samples are decimated,
// watched for a rising/falling level crossing (or an auto-mode timeout), and
// one trace of DEPTH samples is captured into an internal RAM. The trace is
// frozen while the display owns it and is released by frame_done.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   adc_data/valid    ADC sample code and its single-cycle strobe
//   decim             decimation ratio (0 and 1 both keep every sample)
//   trig_level/slope  trigger threshold, 0 = rising, 1 = falling
//   auto_mode         force a trigger after AUTO_TO untriggered samples
//   frame_done        display has released the buffer
//   rd_en/rd_col      column read request (2-cycle latency)
//   rd_data/rd_valid  packed BCD {volts, tenths} and its qualifier
//   ready             a complete trace is readable
//   armed             waiting for a trigger
// ---------------------------------------------------------------------------
module scope_trace_capture #(
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 640,
  parameter int COL_W    = 10,
  parameter int VFS_DV   = 50,
  parameter int AUTO_TO  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic [15:0]         decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic                auto_mode,
  input  logic                frame_done,
  input  logic                rd_en,
  input  logic [COL_W-1:0]    rd_col,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                ready,
  output logic                armed
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(AUTO_TO + 1);
  localparam int PW = SAMPLE_W + $clog2(VFS_DV + 1);

  typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, READY} state_t;

  state_t              state;
  state_t              state_next;
  logic [15:0]         dec_cnt;
  logic [15:0]         dec_max;
  logic                accept;
  logic [SAMPLE_W-1:0] prev;
  logic [TW-1:0]       tmo;
  logic [AW-1:0]       waddr;
  logic                edge_hit;
  logic                force_hit;
  logic                trig;
  logic                we;
  logic [AW-1:0]       wr_addr;

  logic [SAMPLE_W-1:0] mem [0:DEPTH-1];
  logic [SAMPLE_W-1:0] mem_q;
  logic                rd_in_range;
  logic [AW-1:0]       rd_addr;
  logic                rd_v1;
  logic                rd_ok1;

  logic [PW-1:0]       prod;
  logic [PW-1:0]       tenths_full;
  logic [5:0]          t_sat;
  logic [7:0]          conv;

  // ---------------- decimation ----------------
  // ">=" rather than "==" so a ratio lowered mid-count cannot stall.
  assign dec_max = (decim > 16'd1) ? (decim - 16'd1) : 16'd0;
  assign accept  = adc_valid && (state != READY) && (dec_cnt >= dec_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (adc_valid && (state != READY)) begin
      dec_cnt <= accept ? 16'd0 : dec_cnt + 16'd1;
    end
  end

  // ---------------- trigger detection ----------------
  always_comb begin
    edge_hit  = 1'b0;
    if (trig_slope)
      edge_hit = (prev > trig_level) && (adc_data <= trig_level);
    else
      edge_hit = (prev < trig_level) && (adc_data >= trig_level);
    force_hit = auto_mode && (tmo == TW'(AUTO_TO));
    trig      = accept && (state == WAIT_TRIG) && (edge_hit || force_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (accept && ((state == ARM) || (state == WAIT_TRIG))) begin
      prev <= adc_data;
    end
  end

  // Timeout counter saturates so a late enable of auto_mode fires at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (state == ARM) begin
      tmo <= '0;
    end else if (accept && (state == WAIT_TRIG) && !trig && (tmo != TW'(AUTO_TO))) begin
      tmo <= tmo + TW'(1);
    end
  end

  // ---------------- write address ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr <= '0;
    end else if (trig) begin
      waddr <= AW'(1);
    end else if (accept && (state == CAPTURE)) begin
      waddr <= waddr + AW'(1);
    end
  end

  assign we      = trig || (accept && (state == CAPTURE));
  assign wr_addr = trig ? '0 : waddr;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    armed      = 1'b0;
    case (state)
      ARM: begin
        armed = 1'b1;
        if (accept) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        armed = 1'b1;
        if (trig) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (accept && (waddr == AW'(DEPTH - 1))) state_next = READY;
      end
      READY: begin
        ready = 1'b1;
        if (frame_done) state_next = ARM;
      end
      default: state_next = ARM;
    endcase
  end

  // ---------------- trace RAM ----------------
  // Out-of-range columns are steered to address 0; their data is discarded.
  assign rd_in_range = (32'(rd_col) < DEPTH);
  assign rd_addr     = rd_in_range ? AW'(rd_col) : '0;

  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= adc_data;
    if (rd_en) mem_q        <= mem[rd_addr];
  end

  // ---------------- read pipeline ----------------
  // ready is captured with the request, so a release in the same cycle
  // still returns the frozen trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1  <= 1'b0;
      rd_ok1 <= 1'b0;
    end else begin
      rd_v1  <= rd_en;
      rd_ok1 <= rd_en && ready && rd_in_range;
    end
  end

  // code * VFS_DV / 2^SAMPLE_W in tenths of a volt, saturated to 5.9 V.
  always_comb begin
    prod        = PW'(mem_q) * PW'(VFS_DV);
    tenths_full = prod >> SAMPLE_W;
    if (tenths_full > PW'(59)) t_sat = 6'd59;
    else                       t_sat = 6'(tenths_full);
    conv = {4'(t_sat / 6'd10), 4'(t_sat % 6'd10)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_v1;
      if (rd_v1) rd_data <= rd_ok1 ? conv : 8'h00;
    end
  end

endmodule

// File: tb/tb_scope_trace_capture.sv
// ---------------------------------------------------------------------------
// Bench for scope_trace_capture: a sample-level model of the capture rules
// is compared against the DUT outputs every cycle, and directed reads pin
// hand-computed BCD values.
// ---------------------------------------------------------------------------
module tb_scope_trace_capture;

  localparam int SAMPLE_W = 12;
  localparam int DEPTH    = 640;
  localparam int COL_W    = 10;
  localparam int VFS_DV   = 50;
  localparam int AUTO_TO  = 1024;

  logic                clk;
  logic                rst_n;
  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_valid;
  logic [15:0]         decim;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_slope;
  logic                auto_mode;
  logic                frame_done;
  logic                rd_en;
  logic [COL_W-1:0]    rd_col;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                ready;
  logic                armed;

  scope_trace_capture #(
    .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .COL_W(COL_W),
    .VFS_DV(VFS_DV), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .decim(decim), .trig_level(trig_level), .trig_slope(trig_slope),
    .auto_mode(auto_mode), .frame_done(frame_done), .rd_en(rd_en),
    .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid),
    .ready(ready), .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 arming, 1 waiting for trigger, 2 capturing, 3 trace ready.
  int m_phase, m_dec, m_tmo, m_prev, m_waddr;
  int m_mem [DEPTH];
  bit m_p_v, m_rv;
  int m_p_d, m_rd;

  function automatic int to_bcd(input int code);
    int t;
    t = (code * VFS_DV) / (1 << SAMPLE_W);
    if (t > 59) t = 59;
    return (t / 10) * 16 + (t % 10);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_dec = 0; m_tmo = 0; m_prev = 0; m_waddr = 0;
      m_p_v = 0; m_p_d = 0; m_rv = 0; m_rd = 0;
    end else begin
      int lim;
      int cur;
      bit hit;
      // result of the request taken last cycle emerges now
      m_rv = m_p_v;
      if (m_p_v) m_rd = m_p_d;
      m_p_v = rd_en;
      if (rd_en)
        m_p_d = (m_phase == 3 && int'(rd_col) < DEPTH) ? to_bcd(m_mem[rd_col]) : 0;

      if (m_phase == 3) begin
        if (frame_done) m_phase = 0;
      end else if (adc_valid) begin
        lim = (decim > 1) ? int'(decim) - 1 : 0;
        if (m_dec >= lim) begin
          m_dec = 0;
          cur = int'(adc_data);
          case (m_phase)
            0: begin m_prev = cur; m_tmo = 0; m_phase = 1; end
            1: begin
              if (trig_slope) hit = (m_prev > int'(trig_level)) && (cur <= int'(trig_level));
              else            hit = (m_prev < int'(trig_level)) && (cur >= int'(trig_level));
              if (hit || (auto_mode && m_tmo >= AUTO_TO)) begin
                m_mem[0] = cur; m_waddr = 1; m_phase = 2;
              end else if (m_tmo < AUTO_TO) begin
                m_tmo++;
              end
              m_prev = cur;
            end
            default: begin
              m_mem[m_waddr] = cur;
              if (m_waddr == DEPTH - 1) m_phase = 3;
              else m_waddr++;
            end
          endcase
        end else begin
          m_dec++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", int'(ready), int'(m_phase == 3));
    check("armed", int'(armed), int'(m_phase < 2));
    check("rd_valid", int'(rd_valid), int'(m_rv));
    check("rd_data", int'(rd_data), m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int code);
    adc_data  = SAMPLE_W'(code);
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  function automatic int gen(input int kind, input int i);
    case (kind)
      0:       return (i * 512) % 4096;
      1:       return 100;
      default: return (i == 2) ? 4095 : 0;
    endcase
  endfunction

  task automatic run_until_ready(input int kind, input int budget, input int fd_at,
                                 output int n);
    n = 0;
    while (!ready && n < budget) begin
      frame_done = (n == fd_at);
      feed(gen(kind, n));
      frame_done = 1'b0;
      n++;
    end
    check("ready_timeout", int'(ready), 1);
  endtask

  task automatic do_read(input int col, input int exp, input string name);
    rd_en  = 1'b1;
    rd_col = COL_W'(col);
    tick();
    rd_en = 1'b0;
    tick();
    check(name, int'(rd_data), exp);
    check({name, "_valid"}, int'(rd_valid), 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; decim = 16'd1;
    trig_level = 12'd2048; trig_slope = 1'b0; auto_mode = 1'b0;
    frame_done = 1'b0; rd_en = 1'b0; rd_col = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_armed", int'(armed), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Rising ramp, trigger on 2048.
    run_until_ready(0, 2000, -1, n);
    check("ramp_store_count", n, 644);
    do_read(0, 8'h25, "rise_col0");
    do_read(1, 8'h31, "rise_col1");
    do_read(2, 8'h37, "rise_col2");
    do_read(640, 8'h00, "col_out_of_range");
    repeat (5) feed(4095);                      // ignored while READY
    do_read(0, 8'h25, "frozen_col0");
    rd_en = 1'b1;                               // back-to-back reads
    for (int c = 3; c < 6; c++) begin
      rd_col = COL_W'(c);
      tick();
    end
    rd_en = 1'b0;
    tick(); tick();

    // Release and read in the same cycle: the read still sees the trace.
    rd_en = 1'b1; rd_col = 1; frame_done = 1'b1;
    tick();
    rd_en = 1'b0; frame_done = 1'b0;
    check("release_ready", int'(ready), 0);
    check("release_armed", int'(armed), 1);
    tick();
    check("release_read", int'(rd_data), 8'h31);

    // Full scale and zero codes; frame_done mid-capture is ignored.
    run_until_ready(2, 2000, 300, n);
    check("fs_store_count", n, 642);
    do_read(1, 8'h00, "code_zero");
    do_read(0, 8'h49, "code_full");
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;

    // Reset in the middle of a capture.
    for (int i = 0; i < 60; i++) feed(gen(0, i));
    check("midcap_armed", int'(armed), 0);
    rst_n = 1'b0;
    tick();
    check("midrst_armed", int'(armed), 1);
    check("midrst_ready", int'(ready), 0);
    check("midrst_rd_valid", int'(rd_valid), 0);
    check("midrst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    do_read(5, 8'h00, "rd_not_ready");

    // Constant level, auto off: never triggers.
    for (int i = 0; i < 1200; i++) feed(100);
    check("noauto_ready", int'(ready), 0);
    check("noauto_armed", int'(armed), 1);

    // Auto trigger: 1 arming + 1024 misses + trigger + 639 stores.
    pulse_reset();
    auto_mode = 1'b1;
    run_until_ready(1, 2000, -1, n);
    check("auto_store_count", n, 1665);
    do_read(0, 8'h01, "auto_col0");
    do_read(300, 8'h01, "auto_col300");
    do_read(639, 8'h01, "auto_col639");
    auto_mode = 1'b0;

    // Falling ramp.
    pulse_reset();
    trig_slope = 1'b1;
    run_until_ready(0, 2000, -1, n);
    do_read(0, 8'h00, "fall_col0");
    do_read(1, 8'h06, "fall_col1");

    // Falling ramp with decimation by 4.
    pulse_reset();
    decim = 16'd4;
    run_until_ready(0, 4000, -1, n);
    do_read(0, 8'h18, "dec4_col0");
    do_read(1, 8'h43, "dec4_col1");

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
